// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_sub_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Default operand/result width
    localparam int unsigned DEFAULT_WIDTH = 4;

    // Bit-counter width for a given operand width; never narrower than one bit
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// Combinational one-bit full subtractor: d = a - b - bin, bout = borrow out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (a - b - input_borrow), one bit per clock,
// with a start/done handshake. Results are registered and held until the next
// operation completes. Define SERIAL_SUB_OVF_EN to add the signed-overflow port.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             input_borrow,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             output_borrow
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             overflow
`endif
);

    localparam int unsigned CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] part_q, part_d;
    logic             bor_q, bor_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             obor_q, obor_d;

    logic             d_bit;
    logic             bout_bit;
    logic             accept;
    logic             last;

`ifdef SERIAL_SUB_OVF_EN
    // Operand MSBs are shifted out of a_q/b_q, so keep copies for overflow
    logic             amsb_q, amsb_d;
    logic             bmsb_q, bmsb_d;
    logic             ovf_q, ovf_d;
`endif

    full_subtractor u_cell (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .bin  (bor_q),
        .d    (d_bit),
        .bout (bout_bit)
    );

    assign accept = start && ((state_q == IDLE) || (state_q == DONE));
    assign last   = (state_q == SHIFT) && (cnt_q == LAST_BIT);

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        part_d  = part_q;
        bor_d   = bor_q;
        cnt_d   = cnt_q;
        diff_d  = diff_q;
        obor_d  = obor_q;
`ifdef SERIAL_SUB_OVF_EN
        amsb_d  = amsb_q;
        bmsb_d  = bmsb_q;
        ovf_d   = ovf_q;
`endif
        unique case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    a_d     = a;
                    b_d     = b;
                    part_d  = '0;
                    bor_d   = input_borrow;
                    cnt_d   = '0;
                    state_d = SHIFT;
`ifdef SERIAL_SUB_OVF_EN
                    amsb_d  = a[WIDTH-1];
                    bmsb_d  = b[WIDTH-1];
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                a_d    = a_q >> 1;
                b_d    = b_q >> 1;
                part_d = {d_bit, part_q[WIDTH-1:1]};
                bor_d  = bout_bit;
                cnt_d  = cnt_q + CW'(1);
                if (last) begin
                    // Partial result only reaches the ports once complete
                    diff_d  = {d_bit, part_q[WIDTH-1:1]};
                    obor_d  = bout_bit;
                    cnt_d   = '0;
                    state_d = DONE;
`ifdef SERIAL_SUB_OVF_EN
                    ovf_d   = (amsb_q ^ bmsb_q) & (d_bit ^ amsb_q);
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            part_q  <= '0;
            bor_q   <= 1'b0;
            cnt_q   <= '0;
            diff_q  <= '0;
            obor_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            part_q  <= part_d;
            bor_q   <= bor_d;
            cnt_q   <= cnt_d;
            diff_q  <= diff_d;
            obor_q  <= obor_d;
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    // Overflow flag and captured operand MSBs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            amsb_q <= 1'b0;
            bmsb_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            amsb_q <= amsb_d;
            bmsb_q <= bmsb_d;
            ovf_q  <= ovf_d;
        end
    end

    assign overflow = ovf_q;
`endif

    assign busy          = (state_q == SHIFT);
    assign done          = (state_q == DONE);
    assign diff          = diff_q;
    assign output_borrow = obor_q;

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial WIDTH-bit subtractor with a start/done handshake. It computes a − b − input_borrow one bit per clock through a single full-subtractor cell. It is the inverse-operation counterpart of the parallel four-bit adder and sits beside it in the arithmetic lab datapath. Results are registered and held stable until the next operation completes.

## Interface
- WIDTH, 4, operand and result width in bits (≥ 2)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only in IDLE or DONE
- a  in  WIDTH  minuend, captured on accepted start
- b  in  WIDTH  subtrahend, captured on accepted start
- input_borrow  in  1  borrow-in, captured on accepted start
- busy  out  1  high while in SHIFT
- done  out  1  one-cycle pulse: result registers just updated
- diff  out  WIDTH  registered difference
- output_borrow  out  1  registered borrow-out of MSB
- overflow  out  1  signed overflow (present only with SERIAL_SUB_OVF_EN)

One clock; reset is asynchronous and active-low.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: start=1 → capture a, b into shift registers; borrow ← input_borrow; bit counter ← 0; go to SHIFT.
- SHIFT, each cycle:
  - d = a0 ^ b0 ^ bor
  - bnext = (~a0 & b0) | (~(a0 ^ b0) & bor)
  - Shift the a and b registers right by one.
  - Shift d into the MSB of the internal partial-result register.
  - borrow ← bnext; counter++.
- Final SHIFT cycle (counter = WIDTH−1): load diff ← completed partial result and output_borrow ← bnext; go to DONE.
- DONE: done=1 for exactly this cycle.
  - start=1 → accepted as in IDLE, next state SHIFT.
  - Otherwise go to IDLE.
- start in SHIFT is ignored and not queued; operand changes during SHIFT have no effect.
- diff and output_borrow change only on the final SHIFT edge. The partial result is never visible on the ports.
- Arithmetic is modulo 2^WIDTH. output_borrow=1 iff a < b + input_borrow (unsigned).

## Timing
- Reset, asynchronous, any state:
  - state=IDLE, busy=0, done=0, diff=0, output_borrow=0, overflow=0
  - shift registers, counter and borrow cleared
- Reset mid-SHIFT aborts the operation. No done pulse is produced.
- Accept edge E0 (start=1 in IDLE/DONE) → busy=1 from E0 until edge E_WIDTH.
- Bit i is computed at edge E(i+1).
- Edge E_WIDTH loads the result. done=1 and busy=0 in the cycle after E_WIDTH.
- Latency is WIDTH cycles from the accept edge to the done cycle.
- Back-to-back: start held high gives one result every WIDTH+1 cycles.
- busy and done are never high together.

## Configuration
- SERIAL_SUB_OVF_EN defined:
  - overflow port exists.
  - overflow = (a[MSB] ≠ b[MSB]) & (diff[MSB] ≠ a[MSB]), using captured operand MSBs.
  - Registered on the same edge as diff and cleared by reset.
- Undefined: overflow port, its register and its MSB capture logic are absent. All other behaviour is identical.

## Structure
- Package serial_sub_pkg holds:
  - state enum (IDLE, SHIFT, DONE)
  - default WIDTH constant
  - counter-width function/constant $clog2(WIDTH)
- Sub-module full_subtractor: combinational (a, b, bin) → (d, bout), instanced once for the serial bit cell.

## Test plan
- a=0011, b=0001, input_borrow=0 → done 4 cycles after accept; diff=0010, output_borrow=0.
- a=0001, b=0011, input_borrow=0 → diff=1110, output_borrow=1.
- a=0000, b=0000, input_borrow=1 → diff=1111, output_borrow=1.
- a=1000, b=0001 → diff=0111, output_borrow=0, overflow=1 with macro.
  - Also a=0111, b=0001 → diff=0110, overflow=0.
- start pulsed again during SHIFT with different operands → ignored; first result unchanged; single done pulse.
  - start held high continuously → done every 5 cycles.
- rst_n low for 1 cycle mid-SHIFT → all outputs 0, state IDLE, no done.
  - Next start computes correctly (1011−1101 → diff=1110, output_borrow=1).
